vending_machine_ctrl: RTL and testbench

//  Parametrised successor to the single-credit vending FSM: NUM_ITEMS products with per-item price and stock.

---
 rtl/vending_machine_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_vending_machine_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_ctrl.sv
// Vending machine controller: NUM_ITEMS products with per-item price and stock,
// a bounded credit accumulator, a registered vend handshake toward the dispenser
// and a coin-by-coin greedy change handshake toward the hopper.
module vending_machine_ctrl #(
  parameter int CREDIT_W   = 7,
  parameter int MAX_CREDIT = 20,
  parameter int NUM_ITEMS  = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {7'd9, 7'd7, 7'd5, 7'd3},
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 5,
  localparam int IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           moneyin,
  input  logic [NUM_ITEMS-1:0] buy,
  input  logic                 refund,
  input  logic                 restock,
  output logic                 vend_valid,
  output logic [IDX_W-1:0]     vend_item,
  input  logic                 vend_ready,
  output logic                 coin_valid,
  output logic [3:0]           coin_out,
  input  logic                 coin_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic [15:0]          credit_bcd,
  output logic [NUM_ITEMS-1:0] buy_available,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 moneyin_ok,
  output logic                 moneyin_reject,
  output logic                 buy_success,
  output logic                 buy_fail
);

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

  localparam logic [CREDIT_W:0]  MAX_C  = MAX_CREDIT[CREDIT_W:0];
  localparam logic [STOCK_W-1:0] INIT_S = INIT_STOCK[STOCK_W-1:0];

  state_t                              r_state, w_state_nx;
  logic [CREDIT_W-1:0]                 r_credit, w_credit_nx;
  logic [NUM_ITEMS-1:0][STOCK_W-1:0]   r_stock, w_stock_nx;
  logic                                r_vend_valid, w_vend_valid_nx;
  logic [IDX_W-1:0]                    r_vend_item, w_vend_item_nx;
  logic                                r_ok, w_ok_nx;
  logic                                r_reject, w_reject_nx;
  logic                                r_success, w_success_nx;
  logic                                r_fail, w_fail_nx;

  logic [IDX_W-1:0]                    w_buy_idx;
  logic [CREDIT_W-1:0]                 w_buy_price;
  logic                                w_buy_ok;
  logic [CREDIT_W:0]                   w_sum;
  logic [3:0]                          w_change_coin;
  logic [CREDIT_W-1:0]                 w_change_left;

  // Coin one-hot {1000,500,200,100} to credit units of 100 won
  function automatic logic [CREDIT_W-1:0] f_coin_value(input logic [3:0] coin);
    case (coin)
      4'b0001: return CREDIT_W'(1);
      4'b0010: return CREDIT_W'(2);
      4'b0100: return CREDIT_W'(5);
      4'b1000: return CREDIT_W'(10);
      default: return '0;
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit
  function automatic logic [3:0] f_change_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(10))     return 4'b1000;
    else if (c >= CREDIT_W'(5)) return 4'b0100;
    else if (c >= CREDIT_W'(2)) return 4'b0010;
    else                        return 4'b0001;
  endfunction

  function automatic logic [CREDIT_W-1:0] f_price(input logic [IDX_W-1:0] idx);
    return PRICES[idx*CREDIT_W +: CREDIT_W];
  endfunction

  // Display digits: thousands and hundreds of won; tens and ones are always 0
  function automatic logic [15:0] f_bcd(input logic [CREDIT_W-1:0] c);
    logic [CREDIT_W-1:0] q;
    logic [CREDIT_W-1:0] r;
    q = c / CREDIT_W'(10);
    r = c % CREDIT_W'(10);
    return {q[3:0], r[3:0], 8'h00};
  endfunction

  // Encode the pressed button (only meaningful when buy is one-hot)
  always_comb begin
    w_buy_idx = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (buy[i]) w_buy_idx = IDX_W'(i);
    end
  end

  assign w_buy_price   = f_price(w_buy_idx);
  assign w_buy_ok      = (r_credit >= w_buy_price) && (r_stock[w_buy_idx] != '0);
  assign w_sum         = {1'b0, r_credit} + {1'b0, f_coin_value(moneyin)};
  assign w_change_coin = f_change_coin(r_credit);
  assign w_change_left = r_credit - f_coin_value(w_change_coin);

  // Next-state, credit/stock update and status pulse decode
  always_comb begin
    w_state_nx      = r_state;
    w_credit_nx     = r_credit;
    w_stock_nx      = r_stock;
    w_vend_valid_nx = r_vend_valid;
    w_vend_item_nx  = r_vend_item;
    w_ok_nx         = 1'b0;
    w_reject_nx     = 1'b0;
    w_success_nx    = 1'b0;
    w_fail_nx       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (restock) begin
          for (int i = 0; i < NUM_ITEMS; i++) w_stock_nx[i] = INIT_S;
        end else if (refund) begin
          if (r_credit != '0) w_state_nx = S_CHANGE;
        end else if (buy != '0) begin
          if ($onehot(buy) && w_buy_ok) begin
            w_credit_nx            = r_credit - w_buy_price;
            w_stock_nx[w_buy_idx]  = r_stock[w_buy_idx] - STOCK_W'(1);
            w_success_nx           = 1'b1;
            w_vend_valid_nx        = 1'b1;
            w_vend_item_nx         = w_buy_idx;
            w_state_nx             = S_VEND;
          end else begin
            w_fail_nx = 1'b1;
          end
        end else if (moneyin != '0) begin
          if (!$onehot(moneyin) || (w_sum > MAX_C)) begin
            w_reject_nx = 1'b1;
          end else begin
            w_credit_nx = w_sum[CREDIT_W-1:0];
            w_ok_nx     = 1'b1;
          end
        end
      end
      S_VEND: begin
        w_fail_nx   = (buy != '0);
        w_reject_nx = (moneyin != '0);
        if (vend_ready) begin
          w_vend_valid_nx = 1'b0;
          w_state_nx      = S_IDLE;
        end
      end
      S_CHANGE: begin
        w_fail_nx   = (buy != '0);
        w_reject_nx = (moneyin != '0);
        if (coin_ready) begin
          w_credit_nx = w_change_left;
          if (w_change_left == '0) w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, credit, stock and pulse registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= INIT_S;
      r_vend_valid <= 1'b0;
      r_vend_item  <= '0;
      r_ok         <= 1'b0;
      r_reject     <= 1'b0;
      r_success    <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_credit     <= w_credit_nx;
      r_stock      <= w_stock_nx;
      r_vend_valid <= w_vend_valid_nx;
      r_vend_item  <= w_vend_item_nx;
      r_ok         <= w_ok_nx;
      r_reject     <= w_reject_nx;
      r_success    <= w_success_nx;
      r_fail       <= w_fail_nx;
    end
  end

  // Status flags derived from the registers
  always_comb begin
    buy_available = '0;
    sold_out      = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out[i]      = (r_stock[i] == '0);
      buy_available[i] = (r_state == S_IDLE) && (r_credit >= f_price(IDX_W'(i))) &&
                         (r_stock[i] != '0);
    end
  end

  assign vend_valid     = r_vend_valid;
  assign vend_item      = r_vend_item;
  assign coin_valid     = (r_state == S_CHANGE);
  assign coin_out       = (r_state == S_CHANGE) ? w_change_coin : 4'b0000;
  assign credit         = r_credit;
  assign credit_bcd     = f_bcd(r_credit);
  assign moneyin_ok     = r_ok;
  assign moneyin_reject = r_reject;
  assign buy_success    = r_success;
  assign buy_fail       = r_fail;

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Testbench for vending_machine_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the machine.
module tb_vending_machine_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] moneyin;
  logic [3:0] buy;
  logic       refund;
  logic       restock;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       vend_ready;
  logic       coin_valid;
  logic [3:0] coin_out;
  logic       coin_ready;
  logic [6:0] credit;
  logic [15:0] credit_bcd;
  logic [3:0] buy_available;
  logic [3:0] sold_out;
  logic       moneyin_ok;
  logic       moneyin_reject;
  logic       buy_success;
  logic       buy_fail;

  always #5 clk = ~clk;

  vending_machine_ctrl dut (
    .clk(clk), .reset_n(reset_n), .moneyin(moneyin), .buy(buy), .refund(refund),
    .restock(restock), .vend_valid(vend_valid), .vend_item(vend_item),
    .vend_ready(vend_ready), .coin_valid(coin_valid), .coin_out(coin_out),
    .coin_ready(coin_ready), .credit(credit), .credit_bcd(credit_bcd),
    .buy_available(buy_available), .sold_out(sold_out), .moneyin_ok(moneyin_ok),
    .moneyin_reject(moneyin_reject), .buy_success(buy_success), .buy_fail(buy_fail)
  );

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model: mode 0 = idle, 1 = dispensing, 2 = paying change
  int m_credit;
  int m_stock [4];
  int m_mode;
  int m_item;
  bit m_ok, m_rej, m_succ, m_fail;
  int price [4] = '{3, 5, 7, 9};

  function automatic int coin_val(input logic [3:0] c);
    case (c)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 5;
      4'b1000: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] greedy_coin(input int c);
    if (c >= 10) return 4'b1000;
    if (c >= 5)  return 4'b0100;
    if (c >= 2)  return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rn, input logic [3:0] mi, input logic [3:0] by,
                            input logic rf, input logic rs, input logic vr, input logic cr);
    int idx;
    m_ok = 0; m_rej = 0; m_succ = 0; m_fail = 0;
    if (!rn) begin
      m_credit = 0; m_mode = 0; m_item = 0;
      for (int k = 0; k < 4; k++) m_stock[k] = 5;
      return;
    end
    if (m_mode == 0) begin
      if (rs) begin
        for (int k = 0; k < 4; k++) m_stock[k] = 5;
      end else if (rf) begin
        if (m_credit > 0) m_mode = 2;
      end else if (by != 0) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (by[k]) idx = k;
        if ($countones(by) == 1 && m_credit >= price[idx] && m_stock[idx] > 0) begin
          m_credit -= price[idx];
          m_stock[idx] -= 1;
          m_succ = 1; m_mode = 1; m_item = idx;
        end else m_fail = 1;
      end else if (mi != 0) begin
        if ($countones(mi) != 1 || m_credit + coin_val(mi) > 20) m_rej = 1;
        else begin m_credit += coin_val(mi); m_ok = 1; end
      end
    end else begin
      m_fail = (by != 0);
      m_rej  = (mi != 0);
      if (m_mode == 1 && vr) m_mode = 0;
      if (m_mode == 2 && cr) begin
        m_credit -= coin_val(greedy_coin(m_credit));
        if (m_credit == 0) m_mode = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] eba, eso;
    for (int k = 0; k < 4; k++) begin
      eba[k] = (m_mode == 0) && (m_credit >= price[k]) && (m_stock[k] != 0);
      eso[k] = (m_stock[k] == 0);
    end
    chk("credit",     32'(credit),         32'(m_credit));
    chk("credit_bcd", 32'(credit_bcd),     32'(((m_credit / 10) << 12) | ((m_credit % 10) << 8)));
    chk("buy_avail",  32'(buy_available),  32'(eba));
    chk("sold_out",   32'(sold_out),       32'(eso));
    chk("vend_valid", 32'(vend_valid),     32'(m_mode == 1));
    if (m_mode == 1) chk("vend_item", 32'(vend_item), 32'(m_item));
    chk("coin_valid", 32'(coin_valid),     32'(m_mode == 2));
    chk("coin_out",   32'(coin_out),       32'((m_mode == 2) ? greedy_coin(m_credit) : 4'b0000));
    chk("money_ok",   32'(moneyin_ok),     32'(m_ok));
    chk("money_rej",  32'(moneyin_reject), 32'(m_rej));
    chk("buy_succ",   32'(buy_success),    32'(m_succ));
    chk("buy_fail",   32'(buy_fail),       32'(m_fail));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check at the falling edge
  task automatic drive(input logic rn, input logic [3:0] mi, input logic [3:0] by,
                       input logic rf, input logic rs, input logic vr, input logic cr);
    reset_n = rn; moneyin = mi; buy = by; refund = rf; restock = rs;
    vend_ready = vr; coin_ready = cr;
    @(posedge clk);
    model_step(rn, mi, by, rf, rs, vr, cr);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [3:0] rmi, rby;
    int r;
    // 1. reset
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_credit", 32'(credit), 32'(0));
    chk("rst_bcd",    32'(credit_bcd), 32'(16'h0000));
    chk("rst_sold",   32'(sold_out), 32'(4'b0000));
    chk("rst_pulses", 32'({moneyin_ok, moneyin_reject, buy_success, buy_fail}), 32'(0));
    // 2. 500 + 200, buy item 2, stalled vend
    drive(1, 4'b0100, 0, 0, 0, 0, 0);
    chk("t2_ok1", 32'(moneyin_ok), 32'(1));
    drive(1, 4'b0010, 0, 0, 0, 0, 0);
    chk("t2_credit7", 32'(credit), 32'(7));
    chk("t2_avail",   32'(buy_available), 32'(4'b0111));
    drive(1, 0, 4'b0100, 0, 0, 0, 0);
    chk("t2_succ", 32'(buy_success), 32'(1));
    chk("t2_vv",   32'(vend_valid), 32'(1));
    chk("t2_item", 32'(vend_item), 32'(2));
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("t2_vv_hold", 32'(vend_valid), 32'(1));
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("t2_vv_done", 32'(vend_valid), 32'(0));
    // 3. saturation and multi-coin reject
    drive(1, 4'b1000, 0, 0, 0, 0, 0);
    drive(1, 4'b1000, 0, 0, 0, 0, 0);
    chk("t3_bcd", 32'(credit_bcd), 32'(16'h2000));
    drive(1, 4'b0001, 0, 0, 0, 0, 0);
    chk("t3_rej", 32'(moneyin_reject), 32'(1));
    chk("t3_credit", 32'(credit), 32'(20));
    drive(1, 4'b0011, 0, 0, 0, 0, 0);
    chk("t3_multi_rej", 32'(moneyin_reject), 32'(1));
    // drain to zero, then build credit 15
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("t4_drained", 32'(credit), 32'(0));
    drive(1, 4'b1000, 0, 0, 0, 0, 0);
    drive(1, 4'b0100, 0, 0, 0, 0, 0);
    // 4. sell out item 0
    for (int n = 0; n < 5; n++) begin
      drive(1, 0, 4'b0001, 0, 0, 0, 0);
      chk("t4_sale", 32'(buy_success), 32'(1));
      drive(1, 0, 0, 0, 0, 1, 0);
    end
    drive(1, 4'b0100, 0, 0, 0, 0, 0);
    drive(1, 0, 4'b0001, 0, 0, 0, 0);
    chk("t4_fail", 32'(buy_fail), 32'(1));
    chk("t4_sold", 32'(sold_out[0]), 32'(1));
    drive(1, 0, 0, 0, 1, 0, 0);
    chk("t4_restock", 32'(sold_out[0]), 32'(0));
    // 5. change of 8 with stalled hopper
    drive(1, 4'b0010, 0, 0, 0, 0, 0);
    drive(1, 4'b0001, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      drive(1, 0, (n == 1) ? 4'b0001 : 4'b0000, 0, 0, 0, 0);
      chk("t5_stall", 32'(coin_out), 32'(4'b0100));
      if (n == 1) chk("t5_buyfail", 32'(buy_fail), 32'(1));
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("t5_coin200", 32'(coin_out), 32'(4'b0010));
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("t5_coin100", 32'(coin_out), 32'(4'b0001));
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("t5_done", 32'({coin_valid, credit}), 32'(0));
    // 6. reset during vend
    drive(1, 4'b0100, 0, 0, 0, 0, 0);
    drive(1, 4'b0010, 0, 0, 0, 0, 0);
    drive(1, 0, 4'b0001, 0, 0, 0, 0);
    chk("t6_credit4", 32'(credit), 32'(4));
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t6_vv", 32'(vend_valid), 32'(0));
    chk("t6_credit", 32'(credit), 32'(0));
    // 7. random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      rmi = (r < 4) ? 4'b0000 : (r < 8) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      r = $urandom_range(0, 9);
      rby = (r < 6) ? 4'b0000 : (r < 9) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      drive(($urandom_range(0, 99) != 0), rmi, rby, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
